bcd_scan_display: RTL and testbench

Downstream consumer of the decade counter chain. Takes four BCD digits (units, tens, hundreds, thousands) and drives a multiplexed 4-digit seven-segment display. Each digit is scanned in turn at a programmable refresh rate. Input values are snapshotted once per frame so a digit never tears mid-scan. Leading-zero blanking and an invalid-code indicator are included.

---
 rtl/bcd_scan_display.sv | 149 ++++++++++++++
 tb/tb_bcd_scan_display.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Multiplexed 4-digit seven-segment driver for a BCD counter chain.
// Inputs are captured once per frame; outputs are registered and decoded from next-state values.
module bcd_scan_display #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int            CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]    SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic          DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [3:0]    AN_OFF  = {4{AN_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_e;

  slot_e         state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   shadow_dig_q, shadow_dig_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          fd_q, fd_d;

  logic          tick;
  logic          wrap;
  logic          blanked;
  logic          lit;
  logic [3:0]    cur_digit;

  function automatic logic [6:0] seg_map(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= SLOT0;
      cnt_q        <= '0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      fd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      fd_q         <= fd_d;
    end
  end

  always_comb begin
    tick         = enable && (cnt_q == CNT_MAX);
    wrap         = tick && (state_q == SLOT3);
    cnt_d        = cnt_q + 1'b1;
    state_d      = state_q;
    shadow_dig_d = shadow_dig_q;
    shadow_dp_d  = shadow_dp_q;
    fd_d         = wrap;

    if (!enable || tick) begin
      cnt_d = '0;
    end
    if (!enable) begin
      state_d = SLOT0;
    end else if (tick) begin
      state_d = slot_e'(state_q + 2'd1);
    end
    // enable low keeps the shadow transparent so the first slot after enable shows live data
    if (!enable || wrap) begin
      shadow_dig_d = digits;
      shadow_dp_d  = dp_in;
    end

    cur_digit = 4'd0;
    blanked   = 1'b0;
    case (state_d)
      SLOT0: cur_digit = shadow_dig_d[3:0];
      SLOT1: begin
        cur_digit = shadow_dig_d[7:4];
        blanked   = (shadow_dig_d[15:4] == 12'd0);
      end
      SLOT2: begin
        cur_digit = shadow_dig_d[11:8];
        blanked   = (shadow_dig_d[15:8] == 8'd0);
      end
      SLOT3: begin
        cur_digit = shadow_dig_d[15:12];
        blanked   = (shadow_dig_d[15:12] == 4'd0);
      end
      default: begin
        cur_digit = 4'd0;
        blanked   = 1'b0;
      end
    endcase

    lit  = enable && !(blank_lz && blanked);
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    an_d  = AN_OFF;
    if (lit) begin
      seg_d = seg_map(cur_digit) ^ {7{SEG_ACTIVE_LOW}};
      dp_d  = shadow_dp_d[state_d] ^ SEG_ACTIVE_LOW;
      an_d  = (4'b0001 << state_d) ^ {4{AN_ACTIVE_LOW}};
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with REFRESH_DIV=4 and active-low outputs.
// A frame-position model predicts every output on every cycle; literal checks pin known frames.
module tb_bcd_scan_display;

  localparam int R = 4;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_scan_display #(
    .REFRESH_DIV   (R),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .enable    (enable),
    .digits    (digits),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // model: j = number of enabled edges since the scan last restarted
  logic [6:0]  seg_tab [16];
  int          j = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp = 1'b1;
  logic        exp_fd = 1'b0;

  initial begin
    seg_tab[0]  = 7'b0111111; seg_tab[1]  = 7'b0000110;
    seg_tab[2]  = 7'b1011011; seg_tab[3]  = 7'b1001111;
    seg_tab[4]  = 7'b1100110; seg_tab[5]  = 7'b1101101;
    seg_tab[6]  = 7'b1111101; seg_tab[7]  = 7'b0000111;
    seg_tab[8]  = 7'b1111111; seg_tab[9]  = 7'b1101111;
    for (int k = 10; k < 16; k++) seg_tab[k] = 7'b1000000;
  end

  always @(posedge clk or negedge rst_n) begin
    int          slot;
    logic [15:0] hi;
    if (!rst_n) begin
      j = 0; m_dig = '0; m_dp = '0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
    end else if (!enable) begin
      j = 0; m_dig = digits; m_dp = dp_in;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
    end else begin
      j = j + 1;
      exp_fd = ((j % (4 * R)) == 0);
      if (exp_fd) begin
        m_dig = digits;
        m_dp  = dp_in;
      end
      slot = (j / R) % 4;
      hi   = m_dig >> (4 * slot);
      if (blank_lz && slot != 0 && hi == 16'd0) begin
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end else begin
        exp_an  = ~(4'b0001 << slot);
        exp_seg = ~seg_tab[hi[3:0]];
        exp_dp  = ~m_dp[slot];
      end
    end
  end

  // scoreboard helpers
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_an",  {4'b0, an},         {4'b0, exp_an});
    chk("model_seg", {1'b0, seg},        {1'b0, exp_seg});
    chk("model_dp",  {7'b0, dp},         {7'b0, exp_dp});
    chk("model_fd",  {7'b0, frame_done}, {7'b0, exp_fd});
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [3:0] a, input logic [6:0] s,
                            input logic d, input logic f);
    chk({name, "_an"},  {4'b0, an},         {4'b0, a});
    chk({name, "_seg"}, {1'b0, seg},        {1'b0, s});
    chk({name, "_dp"},  {7'b0, dp},         {7'b0, d});
    chk({name, "_fd"},  {7'b0, frame_done}, {7'b0, f});
  endtask

  // one enable-low edge restarts the scan and captures the current inputs
  task automatic resync();
    enable = 1'b0;
    step(1);
    expect_out("resync", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    enable = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; digits = 16'h1234; dp_in = 4'b0000; blank_lz = 1'b0;
    step(2);
    expect_out("in_reset", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    rst_n = 1'b1;
    step(1);
    expect_out("rst_first", 4'b1110, 7'b1000000, 1'b1, 1'b0);
    step(15);
    expect_out("wrap_4", 4'b1110, 7'b0011001, 1'b1, 1'b1);
    step(4);
    expect_out("slot_3", 4'b1101, 7'b0110000, 1'b1, 1'b0);
    step(4);
    expect_out("slot_2", 4'b1011, 7'b0100100, 1'b1, 1'b0);
    step(4);
    expect_out("slot_1", 4'b0111, 7'b1111001, 1'b1, 1'b0);
    step(4);
    expect_out("repeat_4", 4'b1110, 7'b0011001, 1'b1, 1'b1);

    // tearing
    digits = 16'h0009;
    resync();
    step(1);
    expect_out("tear_9", 4'b1110, 7'b0010000, 1'b1, 1'b0);
    step(8);
    digits = 16'h0005;
    step(3);
    expect_out("tear_s3a", 4'b0111, 7'b1000000, 1'b1, 1'b0);
    step(3);
    expect_out("tear_s3b", 4'b0111, 7'b1000000, 1'b1, 1'b0);
    step(1);
    expect_out("tear_5", 4'b1110, 7'b0010010, 1'b1, 1'b1);

    // leading-zero blanking
    blank_lz = 1'b1; digits = 16'h0070;
    resync();
    step(1);
    expect_out("lz_s0", 4'b1110, 7'b1000000, 1'b1, 1'b0);
    step(3);
    expect_out("lz_s1", 4'b1101, 7'b1111000, 1'b1, 1'b0);
    step(4);
    expect_out("lz_s2", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    step(4);
    expect_out("lz_s3", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    digits = 16'h0000; dp_in = 4'b0010;
    resync();
    step(1);
    expect_out("lz0_s0", 4'b1110, 7'b1000000, 1'b1, 1'b0);
    step(3);
    expect_out("lz0_s1dp", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    step(4);
    expect_out("lz0_s2", 4'b1111, 7'b1111111, 1'b1, 1'b0);

    // invalid codes and dp
    blank_lz = 1'b0; digits = 16'hF00A; dp_in = 4'b0100;
    resync();
    step(1);
    expect_out("inv_s0", 4'b1110, 7'b0111111, 1'b1, 1'b0);
    step(3);
    expect_out("inv_s1", 4'b1101, 7'b1000000, 1'b1, 1'b0);
    step(4);
    expect_out("inv_s2dp", 4'b1011, 7'b1000000, 1'b0, 1'b0);
    step(4);
    expect_out("inv_s3", 4'b0111, 7'b0111111, 1'b1, 1'b0);

    // enable dropped mid-frame
    digits = 16'h1234; dp_in = 4'b0000;
    resync();
    step(9);
    expect_out("en_s2", 4'b1011, 7'b0100100, 1'b1, 1'b0);
    enable = 1'b0;
    step(1);
    expect_out("en_off", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    step(10);
    expect_out("en_off_long", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    enable = 1'b1;
    step(1);
    expect_out("en_on", 4'b1110, 7'b0011001, 1'b1, 1'b0);

    // enable falls on the wrap tick
    step(14);
    enable = 1'b0;
    step(1);
    expect_out("en_tick", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    enable = 1'b1;
    step(1);
    expect_out("en_tick_on", 4'b1110, 7'b0011001, 1'b1, 1'b0);
    step(15);
    expect_out("en_tick_wrap", 4'b1110, 7'b0011001, 1'b1, 1'b1);

    // asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(1);
    expect_out("post_rst", 4'b1110, 7'b1000000, 1'b1, 1'b0);
    step(15);
    expect_out("post_rst_wrap", 4'b1110, 7'b0011001, 1'b1, 1'b1);

    // new value with decimal points
    digits = 16'h9876; dp_in = 4'b1001;
    step(16);
    expect_out("dp_s0", 4'b1110, 7'b0000010, 1'b0, 1'b1);
    step(4);
    expect_out("dp_s1", 4'b1101, 7'b1111000, 1'b1, 1'b0);
    step(8);
    expect_out("dp_s3", 4'b0111, 7'b0010000, 1'b0, 1'b0);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
